// File: rtl/fc_1.sv
// fc_1: LeNet FC layer 1; 120 neurons, each a 16-row x 25-lane Q8.8 dot product plus bias, saturated and ReLU'd.
// Latency: one row read per cycle; neuron n is written at cycle 16n+15+RD_LAT+5, and finish rises the cycle after the last write.
// Backpressure: none; the source BRAMs have a fixed read latency and fc_bram always accepts, so the pipeline never stalls.
module fc_1 #(
    parameter int N_OUT  = 120,
    parameter int N_ROW  = 16,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fc_1_en,
    output logic          fm_bram_enb,
    output logic [4:0]    fm_bram_addrb,
    input  logic [1119:0] fm_bram_doutb,
    output logic          w_bram_ena,
    output logic [10:0]   w_bram_addra,
    input  logic [399:0]  w_bram_douta,
    output logic          b_bram_ena,
    output logic [6:0]    b_bram_addra,
    input  logic [15:0]   b_bram_douta,
    output logic          fc_bram_wea,
    output logic [6:0]    fc_bram_addra,
    output logic [15:0]   fc_bram_dina,
    output logic          fc_1_finish
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Travels alongside each row read; the bias field is filled once the bias BRAM data lands.
    typedef struct packed {
        logic        vld;
        logic        first;
        logic        last;
        logic [6:0]  n;
        logic [15:0] bias;
    } meta_t;

    state_t      state;
    state_t      state_nxt;
    logic        fc_1_en_d;
    logic [3:0]  r;
    logic [6:0]  n;
    logic        start;
    logic        last_issue;
    logic        run;

    meta_t       tag_rd [RD_LAT];
    meta_t       rd_out;
    meta_t       tag_p1;
    meta_t       tag_p2;
    meta_t       tag_p3;
    logic        acc_vld;
    logic        acc_last;
    logic [6:0]  acc_n;

    logic [31:0] prod [25];
    logic [34:0] part_sum [5];
    logic [34:0] part [5];
    logic [36:0] total_sum;
    logic [36:0] total;
    logic [40:0] acc;
    logic [40:0] tot_ext;
    logic [40:0] bias_ext;
    logic [15:0] y;
    logic        unused_fm_hi;

    assign run          = (state == RUN);
    assign start        = fc_1_en & ~fc_1_en_d & ~fc_1_finish;
    assign last_issue   = (r == 4'(N_ROW - 1)) && (n == 7'(N_OUT - 1));
    assign unused_fm_hi = ^fm_bram_doutb[1119:400];

    // Read issue: counters sit at 0 outside RUN, so addresses are 0 whenever the enables are low.
    assign fm_bram_enb   = run;
    assign w_bram_ena    = run;
    assign b_bram_ena    = run;
    assign fm_bram_addrb = {1'b0, r};
    assign w_bram_addra  = {n, r};
    assign b_bram_addra  = n;
    assign fc_1_finish   = (state == DONE);

    // State register and start-edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fc_1_en_d <= 1'b0;
        end else begin
            state     <= state_nxt;
            fc_1_en_d <= fc_1_en;
        end
    end

    // Next state: only an IDLE rising edge starts; DONE is left only through reset.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (fc_bram_wea && fc_bram_addra == 7'(N_OUT - 1)) state_nxt = DONE;
            default: state_nxt = state;
        endcase
    end

    // Row/neuron counters step once per RUN cycle and wrap to 0 after the final issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
            n <= '0;
        end else if (run) begin
            if (r == 4'(N_ROW - 1)) begin
                r <= '0;
                n <= (n == 7'(N_OUT - 1)) ? 7'd0 : n + 7'd1;
            end else begin
                r <= r + 4'd1;
            end
        end
    end

    // Attach the bias read result to the tag as it meets the BRAM data.
    always_comb begin
        rd_out      = tag_rd[RD_LAT-1];
        rd_out.bias = b_bram_douta;
    end

    // Tag pipeline: RD_LAT stages of read delay, then one stage per arithmetic stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_rd[i] <= '0;
            tag_p1   <= '0;
            tag_p2   <= '0;
            tag_p3   <= '0;
            acc_vld  <= 1'b0;
            acc_last <= 1'b0;
            acc_n    <= '0;
        end else begin
            tag_rd[0] <= '{vld: run, first: (r == 4'd0), last: (r == 4'(N_ROW - 1)), n: n, bias: 16'h0};
            for (int i = 1; i < RD_LAT; i++) tag_rd[i] <= tag_rd[i-1];
            tag_p1   <= rd_out;
            tag_p2   <= tag_p1;
            tag_p3   <= tag_p2;
            acc_vld  <= tag_p3.vld;
            acc_last <= tag_p3.last;
            acc_n    <= tag_p3.n;
        end
    end

    // Adder tree sums in plain two's complement at full width, so no intermediate can wrap.
    always_comb begin
        total_sum = '0;
        for (int j = 0; j < 5; j++) begin
            part_sum[j] = '0;
            for (int k = 0; k < 5; k++) begin
                part_sum[j] = part_sum[j] + {{3{prod[5*j+k][31]}}, prod[5*j+k]};
            end
            total_sum = total_sum + {{2{part[j][34]}}, part[j]};
        end
    end

    // Multiply, partial-sum and total stages; sign-extending both operands makes the low 32 bits the signed product.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 25; i++) begin
            prod[i] <= {{16{fm_bram_doutb[16*i+15]}}, fm_bram_doutb[16*i +: 16]}
                     * {{16{w_bram_douta[16*i+15]}}, w_bram_douta[16*i +: 16]};
        end
        for (int j = 0; j < 5; j++) part[j] <= part_sum[j];
        total <= total_sum;
    end

    assign tot_ext  = {{4{total[36]}}, total};
    assign bias_ext = {{17{tag_p3.bias[15]}}, tag_p3.bias, 8'h00};

    // Accumulator restarts with the bias on the first row of each neuron.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (tag_p3.vld) begin
            acc <= tag_p3.first ? (tot_ext + bias_ext) : (acc + tot_ext);
        end
    end

    // Drop 8 fraction bits, clamp to 0x7FFF on overflow, zero anything negative.
    always_comb begin
        y = acc[23:8];
        if (acc[40]) begin
            y = 16'h0000;
        end else if (|acc[39:23]) begin
            y = 16'h7FFF;
        end
    end

    // Result write, one cycle after the last accumulate of each neuron.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc_bram_wea   <= 1'b0;
            fc_bram_addra <= '0;
            fc_bram_dina  <= '0;
        end else begin
            fc_bram_wea <= acc_vld & acc_last;
            if (acc_vld && acc_last) begin
                fc_bram_addra <= acc_n;
                fc_bram_dina  <= y;
            end
        end
    end

endmodule

// File: tb/tb_fc_1.sv
module tb_fc_1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fc_1_en = 1'b0;
    logic          fm_bram_enb;
    logic [4:0]    fm_bram_addrb;
    logic [1119:0] fm_bram_doutb = '0;
    logic          w_bram_ena;
    logic [10:0]   w_bram_addra;
    logic [399:0]  w_bram_douta = '0;
    logic          b_bram_ena;
    logic [6:0]    b_bram_addra;
    logic [15:0]   b_bram_douta = '0;
    logic          fc_bram_wea;
    logic [6:0]    fc_bram_addra;
    logic [15:0]   fc_bram_dina;
    logic          fc_1_finish;

    fc_1 dut (
        .clk(clk), .rst(rst), .fc_1_en(fc_1_en),
        .fm_bram_enb(fm_bram_enb), .fm_bram_addrb(fm_bram_addrb), .fm_bram_doutb(fm_bram_doutb),
        .w_bram_ena(w_bram_ena), .w_bram_addra(w_bram_addra), .w_bram_douta(w_bram_douta),
        .b_bram_ena(b_bram_ena), .b_bram_addra(b_bram_addra), .b_bram_douta(b_bram_douta),
        .fc_bram_wea(fc_bram_wea), .fc_bram_addra(fc_bram_addra), .fc_bram_dina(fc_bram_dina),
        .fc_1_finish(fc_1_finish)
    );

    always #5 clk = ~clk;

    // Source BRAMs with two-cycle read latency.
    logic [1119:0] fm_mem [16];
    logic [399:0]  w_mem  [1920];
    logic [15:0]   b_mem  [120];
    logic [1119:0] fm_s1 = '0;
    logic [399:0]  w_s1  = '0;
    logic [15:0]   b_s1  = '0;

    always @(posedge clk) begin
        if (fm_bram_enb) fm_s1 <= fm_mem[fm_bram_addrb[3:0]];
        if (w_bram_ena)  w_s1  <= w_mem[w_bram_addra];
        if (b_bram_ena)  b_s1  <= b_mem[b_bram_addra];
        fm_bram_doutb <= fm_s1;
        w_bram_douta  <= w_s1;
        b_bram_douta  <= b_s1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    logic [15:0] exp_out [120];
    logic [15:0] got_dat [120];
    int wr_cnt, first_wr, fin_cyc, issue_err, timing_err, addr_err, fin_drop;

    task automatic junk_fm_hi();
        for (int r = 0; r < 16; r++)
            for (int b = 400; b < 1120; b++) fm_mem[r][b] = 1'($urandom);
    endtask

    task automatic fill_uniform(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b);
        for (int r = 0; r < 16; r++)
            for (int l = 0; l < 25; l++) fm_mem[r][16*l +: 16] = a;
        for (int i = 0; i < 1920; i++)
            for (int l = 0; l < 25; l++) w_mem[i][16*l +: 16] = w;
        for (int i = 0; i < 120; i++) b_mem[i] = b;
        junk_fm_hi();
    endtask

    task automatic fill_single(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b);
        fill_uniform(16'h0000, 16'h0000, b);
        fm_mem[0][15:0]  = a;
        w_mem[80][15:0]  = w;
    endtask

    task automatic fill_random(input bit full);
        int v;
        for (int r = 0; r < 16; r++)
            for (int l = 0; l < 25; l++) begin
                v = full ? int'($urandom) : int'($urandom_range(512, 0)) - 256;
                fm_mem[r][16*l +: 16] = v[15:0];
            end
        for (int i = 0; i < 1920; i++)
            for (int l = 0; l < 25; l++) begin
                v = full ? int'($urandom) : int'($urandom_range(128, 0)) - 64;
                w_mem[i][16*l +: 16] = v[15:0];
            end
        for (int i = 0; i < 120; i++) begin
            v = full ? int'($urandom) : int'($urandom_range(4096, 0)) - 2048;
            b_mem[i] = v[15:0];
        end
        junk_fm_hi();
    endtask

    // Reference: exact integer dot product, floor-shift, clamp to [0, 0x7FFF].
    task automatic model();
        longint s;
        for (int n = 0; n < 120; n++) begin
            s = longint'($signed(b_mem[n])) * 256;
            for (int r = 0; r < 16; r++)
                for (int l = 0; l < 25; l++)
                    s += longint'($signed(fm_mem[r][16*l +: 16])) * longint'($signed(w_mem[16*n+r][16*l +: 16]));
            s = s >>> 8;
            if (s > 32767) s = 32767;
            if (s < 0) s = 0;
            exp_out[n] = 16'(s);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fc_1_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts a run and samples every cycle 0..last_c (cycle 0 = first RUN cycle).
    // mode 0: one-cycle enable pulse; mode 1: enable held high with extra edges during RUN and DONE.
    task automatic run_collect(input int mode, input int last_c);
        wr_cnt = 0; first_wr = -1; fin_cyc = -1;
        issue_err = 0; timing_err = 0; addr_err = 0; fin_drop = 0;
        for (int i = 0; i < 120; i++) got_dat[i] = 16'hDEAD;
        @(negedge clk);
        fc_1_en = 1'b1;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            if (mode == 1) begin
                if (c == 300 || c == 1950) fc_1_en = 1'b0;
                else if (c == 302 || c == 1952) fc_1_en = 1'b1;
            end else if (c == 0) begin
                fc_1_en = 1'b0;
            end
            if (c < 1920) begin
                if (!(fm_bram_enb && w_bram_ena && b_bram_ena) || int'(fm_bram_addrb) != c % 16
                    || int'(w_bram_addra) != c || int'(b_bram_addra) != c / 16) issue_err++;
            end else if (fm_bram_enb || w_bram_ena || b_bram_ena) begin
                issue_err++;
            end
            if (fc_bram_wea) begin
                if (first_wr < 0) first_wr = c;
                if (c != 16 * wr_cnt + 22) timing_err++;
                if (int'(fc_bram_addra) != wr_cnt) addr_err++;
                if (wr_cnt < 120) got_dat[wr_cnt] = fc_bram_dina;
                wr_cnt++;
            end
            if (fin_cyc < 0 && fc_1_finish) fin_cyc = c;
            else if (fin_cyc >= 0 && !fc_1_finish) fin_drop++;
        end
    endtask

    task automatic check_run(input string tag);
        chk({tag, " writes"}, wr_cnt, 120);
        chk({tag, " first_wr"}, first_wr, 22);
        chk({tag, " finish_cyc"}, fin_cyc, 1927);
        chk({tag, " issue_seq"}, issue_err, 0);
        chk({tag, " wr_timing"}, timing_err, 0);
        chk({tag, " wr_addr"}, addr_err, 0);
        chk({tag, " finish_sticky"}, fin_drop, 0);
        for (int n = 0; n < 120; n++)
            chk($sformatf("%s out[%0d]", tag, n), got_dat[n], exp_out[n]);
    endtask

    typedef struct {
        string       name;
        int          kind;   // 0 uniform fill, 1 single product at neuron 5
        logic [15:0] act;
        logic [15:0] wt;
        logic [15:0] bias;
        logic [15:0] exp5;
        logic [15:0] exp_oth;
    } vec_t;

    vec_t vecs [6];
    int   quiet;

    initial begin
        vecs[0] = '{"bias_only",  0, 16'h1234, 16'h0000, 16'h0100, 16'h0100, 16'h0100};
        vecs[1] = '{"single",     1, 16'h0200, 16'h0180, 16'h0000, 16'h0300, 16'h0000};
        vecs[2] = '{"neg_relu",   1, 16'h0200, 16'hFE80, 16'h0080, 16'h0000, 16'h0080};
        vecs[3] = '{"sat_pos",    0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};
        vecs[4] = '{"sat_neg",    0, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{"neg_bias",   0, 16'h0100, 16'h0001, 16'hFF00, 16'h0090, 16'h0090};

        fill_uniform(16'h0, 16'h0, 16'h0);
        do_reset();
        chk("rst fm_bram_enb", fm_bram_enb, 0);
        chk("rst w_bram_ena", w_bram_ena, 0);
        chk("rst b_bram_ena", b_bram_ena, 0);
        chk("rst addrs", {fm_bram_addrb, w_bram_addra, b_bram_addra}, 0);
        chk("rst fc_bram_wea", fc_bram_wea, 0);
        chk("rst fc_bram_addra", fc_bram_addra, 0);
        chk("rst fc_bram_dina", fc_bram_dina, 0);
        chk("rst fc_1_finish", fc_1_finish, 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            if (vecs[i].kind == 1) fill_single(vecs[i].act, vecs[i].wt, vecs[i].bias);
            else fill_uniform(vecs[i].act, vecs[i].wt, vecs[i].bias);
            for (int n = 0; n < 120; n++) exp_out[n] = (n == 5) ? vecs[i].exp5 : vecs[i].exp_oth;
            run_collect(0, 1940);
            check_run(vecs[i].name);
        end

        for (int k = 0; k < 2; k++) begin
            do_reset();
            fill_random(k == 1);
            model();
            run_collect(0, 1940);
            check_run(k == 1 ? "rand_full" : "rand_small");
        end

        // Reset in the middle of a run, then restart from a fresh edge.
        do_reset();
        fill_uniform(16'h1234, 16'h0000, 16'h0100);
        run_collect(0, 500);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid outputs", {fm_bram_enb, fm_bram_addrb, w_bram_ena, w_bram_addra, b_bram_ena,
                                b_bram_addra, fc_bram_wea, fc_bram_addra, fc_bram_dina, fc_1_finish}, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (fc_bram_wea || fm_bram_enb || w_bram_ena || b_bram_ena || fc_1_finish) quiet++;
        end
        chk("rst_mid quiet", quiet, 0);
        fill_random(1'b0);
        model();
        run_collect(0, 1940);
        check_run("restart");

        // Enable held high with retrigger edges during RUN and DONE.
        do_reset();
        fill_uniform(16'h0100, 16'h0001, 16'hFF00);
        for (int n = 0; n < 120; n++) exp_out[n] = 16'h0090;
        run_collect(1, 2100);
        check_run("level_retrig");
        chk("level finish_end", fc_1_finish, 1);
        fc_1_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_1.md
# fc_1

First fully-connected layer of the LeNet datapath, directly downstream of `pool_2`. Once `pool_2` finishes, it reads the 16×5×5 pooled feature map from `fm_bram`, which holds 16 rows with 25 valid 16-bit activations per row. For each of 120 output neurons it computes a signed fixed-point dot product against weights from a weight BRAM, adds a per-neuron bias and applies saturation and ReLU. Results are written one per neuron into `fc_bram` for the next layer.

## Interface
- `N_OUT`, 120: output neurons.
- `N_ROW`, 16: `fm_bram` rows per neuron.
- `RD_LAT`, 2: read latency of all source BRAMs, in cycles from address register to valid dout.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fc_1_en` in 1: start; a rising edge starts a run (connect to `pool_2_finish`).
- `fm_bram_enb` out 1: feature-map read enable.
- `fm_bram_addrb` out 5: feature-map row address, 0..15.
- `fm_bram_doutb` in 1120: row data; only bits [399:0] are used (25 lanes × 16 bits, lane i = bits [16i+15:16i]).
- `w_bram_ena` out 1: weight read enable.
- `w_bram_addra` out 11: weight address = n·16 + r.
- `w_bram_douta` in 400: 25 weights, lane-aligned with activations.
- `b_bram_ena` out 1: bias read enable.
- `b_bram_addra` out 7: bias address = n.
- `b_bram_douta` in 16: bias, Q8.8.
- `fc_bram_wea` out 1: result write strobe.
- `fc_bram_addra` out 7: result address = n.
- `fc_bram_dina` out 16: result, Q8.8, range 0..0x7FFF.
- `fc_1_finish` out 1: sticky done flag.

## Operation
- **Reset values.** All outputs are 0 after reset, including enables, addresses, `fc_bram_dina` and `fc_1_finish`. The FSM resets to IDLE.
- **FSM.**
  - IDLE → RUN on `fc_1_en & ~fc_1_en_d & ~fc_1_finish`. `fc_1_en_d` is `fc_1_en` registered.
  - RUN → DRAIN after the issue cycle of (n=119, r=15).
  - DRAIN → DONE after the final write.
  - DONE holds until `rst`.
- **RUN issue sequence.** One read is issued per cycle; r counts 0..15 and n counts 0..119.
  - `fm_bram_addrb` = r.
  - `w_bram_addra` = 16n + r.
  - `b_bram_addra` = n.
  - All three enables are 1 only in RUN.
- **Tag pipeline.** A tag {first = (r==0), last = (r==15), n} travels with each issue and is delayed to match the data path.
- **Arithmetic.** All values are signed two's complement Q8.8.
  - Multiply: 25 products, each 16×16 → 32 bits, registered.
  - Adder tree: five 5-input partial sums (35 bits), registered; then the total of the partials (37 bits), registered.
  - Accumulate into a 41-bit accumulator: `acc = first ? total + (sext(bias) << 8) : acc + total`. The bias is the value read with r=0, carried in the tag path.
  - Output, computed on last: `y = acc >>> 8` (truncate), saturate to [−32768, 32767], then ReLU (negative → 0).
- **Write.** One cycle after the last accumulate: `fc_bram_wea`=1 for one cycle, `fc_bram_addra`=n, `fc_bram_dina`=y.
- **Boundary behaviour.**
  - `fc_1_en` deasserting during RUN does not abort the run.
  - Rising edges of `fc_1_en` during RUN, DRAIN or DONE are ignored.
  - A new run requires `rst`.
  - `rst` mid-run: every output and the FSM return to reset values on the next edge, and no further writes occur.
  - `fm_bram_doutb[1119:400]` is ignored.

## Timing
- Cycle 0 is the first RUN cycle, one cycle after the edge where the rising edge of `fc_1_en` is sampled.
- Reads are issued at cycles 0..1919, back-to-back with no bubbles. Row r of neuron n is issued at cycle 16n + r.
- Data for an issue at cycle t is valid at t+RD_LAT.
- Pipeline stages after valid data: products +1, partials +2, total +3, accumulator +4, write +5.
- Write latency: `fc_bram_wea` for neuron n is high at cycle 16n + 15 + RD_LAT + 5, i.e. 16n+22 at default. Writes repeat every 16 cycles.
- The last write is at cycle 1926. `fc_1_finish` rises at cycle 1927 and stays high until `rst`.
- Each write asserts `fc_bram_wea` for exactly one cycle, giving exactly 120 write cycles per run.

## Test plan
- **Bias only.** Set all weights to 0 and every bias to 0x0100, then pulse `fc_1_en` for 1 cycle. Required: 120 writes with addresses 0..119 in order, all data 0x0100. First write at cycle 22, finish at cycle 1927.
- **Single product.** Set bias to 0. Set activation row 0, lane 0 to 0x0200. Set the weight at address 5·16+0, lane 0, to 0x0180. All other values are 0. Required: out[5] = 0x0300, all other outputs 0.
- **Negative and ReLU.** Same as the single-product case but with weight 0xFE80 (−1.5) and bias 0x0080. Required: out[5] = 0 (clamped). Other outputs = 0x0080.
- **Saturation.** Set all activations and weights to 0x7FFF, bias 0. Required: all outputs 0x7FFF with no wrap. Then set all weights to 0x8000. Required: all outputs 0.
- **Reset mid-run.** Assert `rst` at cycle 500. Required: all outputs are 0 the next cycle and no writes occur. A later `fc_1_en` edge restarts with `w_bram_addra` = 0 and produces a full 120-write run.
- **Enable level and retrigger.** Hold `fc_1_en` high through and after finish, and add an extra rising edge during RUN. Required: exactly one run, 120 writes, and `fc_1_finish` stays 1 with no new reads.
